aq_sigcap_trig: RTL
===================

Name: aq_sigcap_trig

Overview:
Trigger and capture sequencer for the signal-capture buffer. It runs in the capture clock domain and drives the 1024x32 capture RAM write port (A port). Once armed, it streams CAP_DATA into the RAM as a ring and collects a programmable pre-trigger history. It then waits for a masked-value trigger, collects a programmable post-trigger count and stops. It reports the trigger address and the window start address so the register side can read the window back through the B port.

Parameters:
ADDR_W, 10, capture RAM address width (depth = 2**ADDR_W)
DATA_W, 32, sample width

Ports:
CLK  in  1  capture clock (CAP_CLK at instantiation)
RST  in  1  synchronous active-high reset
ARM  in  1  single-cycle pulse; starts a capture from IDLE or DONE
ABORT  in  1  single-cycle pulse; returns to IDLE from any state
FORCE_TRIG  in  1  treat the current sample as the trigger (honoured in WAIT only)
TRIG_MASK  in  DATA_W  bits compared for the trigger
TRIG_VALUE  in  DATA_W  required value of the masked bits
PRE_COUNT  in  ADDR_W  samples to store before the trigger is enabled
POST_COUNT  in  ADDR_W  samples to store after the trigger sample
CAP_DATA  in  DATA_W  sample input, one sample per CLK
A_ADDR  out  ADDR_W  RAM write address
A_WE  out  4  RAM byte write enables
A_DO  out  DATA_W  RAM write data
BUSY  out  1  high in PRE, WAIT and POST
TRIGGERED  out  1  high from the trigger write until the next ARM or ABORT
DONE  out  1  high in DONE
TRIG_ADDR  out  ADDR_W  RAM address of the trigger sample
START_ADDR  out  ADDR_W  (TRIG_ADDR - PRE_COUNT) mod 2**ADDR_W; address of the oldest window sample

Behaviour:
- Reset: all outputs 0. State is IDLE. Write pointer wp = 0. Counters are 0.
- States: IDLE, PRE, WAIT, POST, DONE.
- ARM latches TRIG_MASK, TRIG_VALUE, PRE_COUNT and POST_COUNT. Later changes to these inputs have no effect until the next ARM. ARM sets wp = 0, clears the count and clears TRIGGERED and DONE. The state goes to PRE, or to WAIT if PRE_COUNT = 0.
- ARM is ignored in PRE, WAIT and POST.
- ABORT in any state: next cycle the state is IDLE and A_WE = 0. BUSY, DONE and TRIGGERED are cleared. TRIG_ADDR and START_ADDR hold.
- ABORT and ARM in the same cycle: ABORT wins.
- Capture write, in every PRE, WAIT or POST cycle (registered, 1-cycle latency):
  - A_ADDR <= wp; A_DO <= CAP_DATA; A_WE <= 4'hF.
  - wp <= wp + 1, wrapping from 2**ADDR_W-1 to 0.
- A_WE = 0 in every other cycle, including the first cycle after entering IDLE or DONE.
- PRE: count the samples written. When the count reaches the latched PRE_COUNT, go to WAIT. The trigger is not evaluated in PRE.
- WAIT: match = ((CAP_DATA ^ TRIG_VALUE) & TRIG_MASK) == 0, or FORCE_TRIG = 1.
  - TRIG_MASK = 0 triggers on the first WAIT sample.
  - A matching sample is written normally and is the trigger sample.
  - On match: TRIG_ADDR <= wp, START_ADDR <= wp - PRE_COUNT (mod depth), TRIGGERED <= 1.
  - Next state is POST, or DONE if POST_COUNT = 0.
  - No match: remain in WAIT. The ring keeps overwriting the oldest samples indefinitely.
- POST: write exactly POST_COUNT more samples, then go to DONE.
- DONE: hold all status outputs. ARM re-arms; ABORT goes to IDLE.
- Oversize window: if PRE_COUNT + POST_COUNT + 1 > 2**ADDR_W, the oldest samples are overwritten. START_ADDR is still computed as above. The register side is responsible for clamping; this block does no range checking.
- Every sample presented in PRE, WAIT and POST is written; there are no dropped or duplicated samples.
- Reset asserted mid-capture behaves as in the Reset rule on the next edge. The RAM contents are not cleared.

Test Plan:
- Reset, then idle 10 cycles -> A_WE = 0, BUSY = 0, DONE = 0, TRIG_ADDR = 0.
- PRE = 4, POST = 3, MASK = 0xFFFFFFFF, VALUE = 0x55, CAP_DATA = incrementing count starting 0x50 on the ARM+1 cycle.
  - Pre-fill (addresses 0-3): 0x50 to 0x53 are written.
  - Trigger: 0x55 at address 5, so TRIG_ADDR = 5 and START_ADDR = 1.
  - Post: addresses 6-8 hold 0x56 to 0x58. DONE rises 1 cycle after the address-8 write. Exactly 9 writes occur.
- MASK = 0 with PRE = 0, POST = 0 -> one write at address 0, then TRIG_ADDR = 0, START_ADDR = 0, DONE = 1.
- PRE = 2 with no match for 1030 samples -> wp wraps past 1023 to 0. FORCE_TRIG pulsed during PRE has no effect; during WAIT it triggers at the current wp and START_ADDR = wp - 2 mod 1024.
- ABORT mid-POST -> next cycle A_WE = 0, BUSY = 0, TRIGGERED = 0. ARM and ABORT pulsed together -> IDLE. ARM pulsed during WAIT -> ignored.
- Re-ARM from DONE with new PRE = 1 -> wp restarts at 0, DONE and TRIGGERED clear, and the new window is correct.

Source files
------------

// File: rtl/aq_sigcap_trig_if.sv
// ---------------------------------------------------------------------------
// aq_sigcap_trig_if
// Write port (A port) of the 1024x32 signal-capture RAM.
//
// Signals:
//   A_ADDR  RAM write address
//   A_WE    per-byte write enables (all four set for a capture write)
//   A_DO    RAM write data
//
// Modports:
//   master  the capture sequencer, which drives the port
//   slave   the RAM, or a bench monitor, which receives it
// ---------------------------------------------------------------------------
interface aq_sigcap_trig_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] A_ADDR;
    logic [3:0]        A_WE;
    logic [DATA_W-1:0] A_DO;

    modport master (
        output A_ADDR,
        output A_WE,
        output A_DO
    );

    modport slave (
        input A_ADDR,
        input A_WE,
        input A_DO
    );
endinterface

// File: rtl/aq_sigcap_trig.sv
// ---------------------------------------------------------------------------
// aq_sigcap_trig
// Trigger and capture sequencer for the signal-capture buffer. It runs in the
// capture clock domain. Once armed, it streams CAP_DATA into the capture RAM
// as a ring, collects PRE_COUNT samples of history, waits for a masked-value
// (or forced) trigger, collects POST_COUNT more samples and stops. It reports
// where the trigger landed and where the window starts, so the register side
// can read the window back through the RAM's B port.
//
// Ports:
//   CLK, RST      capture clock, synchronous active-high reset
//   ARM           pulse: latch the set-up and start a capture (IDLE/DONE only)
//   ABORT         pulse: return to IDLE from any state (wins over ARM)
//   FORCE_TRIG    treat the current sample as the trigger (WAIT only)
//   TRIG_MASK     bits of CAP_DATA compared for the trigger
//   TRIG_VALUE    required value of the masked bits
//   PRE_COUNT     samples stored before the trigger is enabled
//   POST_COUNT    samples stored after the trigger sample
//   CAP_DATA      sample input, one per CLK
//   ram_a         RAM write port (A_ADDR, A_WE, A_DO), registered
//   BUSY          high while capturing (PRE, WAIT, POST)
//   TRIGGERED     high from the trigger write until the next ARM or ABORT
//   DONE          high once the window is complete
//   TRIG_ADDR     RAM address of the trigger sample
//   START_ADDR    RAM address of the oldest window sample
// ---------------------------------------------------------------------------
module aq_sigcap_trig #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ARM,
    input  logic                    ABORT,
    input  logic                    FORCE_TRIG,
    input  logic [DATA_W-1:0]       TRIG_MASK,
    input  logic [DATA_W-1:0]       TRIG_VALUE,
    input  logic [ADDR_W-1:0]       PRE_COUNT,
    input  logic [ADDR_W-1:0]       POST_COUNT,
    input  logic [DATA_W-1:0]       CAP_DATA,
    aq_sigcap_trig_if.master        ram_a,
    output logic                    BUSY,
    output logic                    TRIGGERED,
    output logic                    DONE,
    output logic [ADDR_W-1:0]       TRIG_ADDR,
    output logic [ADDR_W-1:0]       START_ADDR
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    // One bit wider than the address so the increment can never alias to 0.
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] value_q;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic              capturing;
    logic              trig_hit;

    function automatic logic is_match(
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] value,
        input logic [DATA_W-1:0] mask,
        input logic              force_trig
    );
        return (((data ^ value) & mask) == '0) || force_trig;
    endfunction

    function automatic logic count_reached(
        input logic [ADDR_W:0]   count,
        input logic [ADDR_W-1:0] target
    );
        return count == {1'b0, target};
    endfunction

    assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign cnt_inc   = cnt + (ADDR_W+1)'(1);
    assign trig_hit  = is_match(CAP_DATA, value_q, mask_q, FORCE_TRIG);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            wp           <= '0;
            cnt          <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            ram_a.A_ADDR <= '0;
            ram_a.A_WE   <= '0;
            ram_a.A_DO   <= '0;
            BUSY         <= 1'b0;
            TRIGGERED    <= 1'b0;
            DONE         <= 1'b0;
            TRIG_ADDR    <= '0;
            START_ADDR   <= '0;
        end else if (ABORT) begin
            // Trigger/start addresses are kept so a partial window can still be inspected.
            state      <= S_IDLE;
            ram_a.A_WE <= '0;
            BUSY       <= 1'b0;
            TRIGGERED  <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            ram_a.A_WE <= '0;

            // Every sample seen while capturing goes into the ring, trigger sample included.
            if (capturing) begin
                ram_a.A_ADDR <= wp;
                ram_a.A_DO   <= CAP_DATA;
                ram_a.A_WE   <= 4'hF;
                wp           <= wp + ADDR_W'(1);
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (ARM) begin
                        mask_q    <= TRIG_MASK;
                        value_q   <= TRIG_VALUE;
                        pre_q     <= PRE_COUNT;
                        post_q    <= POST_COUNT;
                        wp        <= '0;
                        cnt       <= '0;
                        TRIGGERED <= 1'b0;
                        DONE      <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= (PRE_COUNT == '0) ? S_WAIT : S_PRE;
                    end
                end

                S_PRE: begin
                    if (count_reached(cnt_inc, pre_q)) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_WAIT: begin
                    if (trig_hit) begin
                        TRIG_ADDR  <= wp;
                        // Modular subtraction: the window may straddle the ring wrap.
                        START_ADDR <= wp - pre_q;
                        TRIGGERED  <= 1'b1;
                        cnt        <= '0;
                        if (post_q == '0) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (count_reached(cnt_inc, post_q)) begin
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
